// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: address map, mstatus bit positions, misa value.
package csr_file_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned HALF_W = 32;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS  = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MISA     = 12'h301;
  localparam logic [CSR_AW-1:0] CSR_MIE      = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC    = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC     = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE   = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL    = 12'h343;
  localparam logic [CSR_AW-1:0] CSR_MIP      = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MINSTRET = 12'hB02;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [CSR_AW-1:0] CSR_MINSTRETH= 12'hB82;
  localparam logic [CSR_AW-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_AW-1:0] CSR_INSTRET  = 12'hC02;
  localparam logic [CSR_AW-1:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [CSR_AW-1:0] CSR_INSTRETH = 12'hC82;
  localparam logic [CSR_AW-1:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;

  localparam logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100;

  // Low two bits cleared on mtvec/mepc stores
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Write-port payload from the write stage
  typedef struct packed {
    logic              en;
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } csr_wr_t;

  // Assemble the architectural mstatus view; MPP is hardwired to machine mode
  function automatic logic [XLEN-1:0] mstatus_pack(input logic mie, input logic mpie);
    logic [XLEN-1:0] v;
    v = '0;
    v[MSTATUS_MIE_BIT]  = mie;
    v[MSTATUS_MPIE_BIT] = mpie;
    v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and per-half write; a write wins over the increment.
module csr_counter64
  import csr_file_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_inc,
  input  logic              i_we_lo,
  input  logic              i_we_hi,
  input  logic [HALF_W-1:0] i_wdata,
  output logic [CNT_W-1:0]  o_count
);

  logic [CNT_W-1:0] r_count;

  // Half write replaces that half only and suppresses the increment for the cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_we_lo) begin
      r_count[HALF_W-1:0] <= i_wdata;
    end else if (i_we_hi) begin
      r_count[CNT_W-1:HALF_W] <= i_wdata;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, single write port, trap/mret sequencing, counters.
module csr_file
  import csr_file_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [CSR_AW-1:0] r_addr,
  output logic [XLEN-1:0]   r_data,
  output logic              r_illegal,
  input  logic              w_enabled,
  input  logic [CSR_AW-1:0] w_addr,
  input  logic [XLEN-1:0]   w_data,
  input  logic              retire,
  input  logic              trap,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic              mret,
  output logic [XLEN-1:0]   mtvec_out,
  output logic [XLEN-1:0]   mepc_out
);

  csr_wr_t w_wr;

  logic r_mstatus_mie;
  logic r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic [CNT_W-1:0] w_mcycle;
  logic [CNT_W-1:0] w_minstret;

  logic w_sys_event;
  logic w_we_mstatus, w_we_mie, w_we_mtvec, w_we_mscratch;
  logic w_we_mepc, w_we_mcause, w_we_mtval;
  logic w_we_mcycle_lo, w_we_mcycle_hi, w_we_minstret_lo, w_we_minstret_hi;

  logic [XLEN-1:0] w_rdata;
  logic            w_illegal;

  assign w_wr.en   = w_enabled;
  assign w_wr.addr = w_addr;
  assign w_wr.data = w_data;

  // Trap/mret own mstatus, mepc and mcause in their cycle; other CSR writes proceed
  assign w_sys_event      = trap | mret;
  assign w_we_mstatus     = w_wr.en && (w_wr.addr == CSR_MSTATUS) && !w_sys_event;
  assign w_we_mepc        = w_wr.en && (w_wr.addr == CSR_MEPC)    && !w_sys_event;
  assign w_we_mcause      = w_wr.en && (w_wr.addr == CSR_MCAUSE)  && !w_sys_event;
  assign w_we_mie         = w_wr.en && (w_wr.addr == CSR_MIE);
  assign w_we_mtvec       = w_wr.en && (w_wr.addr == CSR_MTVEC);
  assign w_we_mscratch    = w_wr.en && (w_wr.addr == CSR_MSCRATCH);
  assign w_we_mtval       = w_wr.en && (w_wr.addr == CSR_MTVAL);
  assign w_we_mcycle_lo   = w_wr.en && (w_wr.addr == CSR_MCYCLE);
  assign w_we_mcycle_hi   = w_wr.en && (w_wr.addr == CSR_MCYCLEH);
  assign w_we_minstret_lo = w_wr.en && (w_wr.addr == CSR_MINSTRET);
  assign w_we_minstret_hi = w_wr.en && (w_wr.addr == CSR_MINSTRETH);

  // mstatus interrupt-enable stack: trap beats mret beats software write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
    end else if (trap) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_we_mstatus) begin
      r_mstatus_mie  <= w_wr.data[MSTATUS_MIE_BIT];
      r_mstatus_mpie <= w_wr.data[MSTATUS_MPIE_BIT];
    end
  end

  // Trap entry captures the faulting pc and cause
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (trap) begin
      r_mepc   <= trap_pc & ALIGN_MASK;
      r_mcause <= trap_cause;
    end else begin
      if (w_we_mepc)   r_mepc   <= w_wr.data & ALIGN_MASK;
      if (w_we_mcause) r_mcause <= w_wr.data;
    end
  end

  // Plain software-writable CSRs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mtval    <= '0;
    end else begin
      if (w_we_mie)      r_mie      <= w_wr.data;
      if (w_we_mtvec)    r_mtvec    <= w_wr.data & ALIGN_MASK;
      if (w_we_mscratch) r_mscratch <= w_wr.data;
      if (w_we_mtval)    r_mtval    <= w_wr.data;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (1'b1),
    .i_we_lo (w_we_mcycle_lo),
    .i_we_hi (w_we_mcycle_hi),
    .i_wdata (w_wr.data),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (retire),
    .i_we_lo (w_we_minstret_lo),
    .i_we_hi (w_we_minstret_hi),
    .i_wdata (w_wr.data),
    .o_count (w_minstret)
  );

  // Read mux over current state; unimplemented addresses flag illegal and return zero
  always_comb begin
    w_rdata   = '0;
    w_illegal = 1'b0;
    case (r_addr)
      CSR_MSTATUS:                w_rdata = mstatus_pack(r_mstatus_mie, r_mstatus_mpie);
      CSR_MISA:                   w_rdata = MISA_VALUE;
      CSR_MIE:                    w_rdata = r_mie;
      CSR_MTVEC:                  w_rdata = r_mtvec;
      CSR_MSCRATCH:               w_rdata = r_mscratch;
      CSR_MEPC:                   w_rdata = r_mepc;
      CSR_MCAUSE:                 w_rdata = r_mcause;
      CSR_MTVAL:                  w_rdata = r_mtval;
      CSR_MIP, CSR_MHARTID:       w_rdata = '0;
      CSR_MCYCLE, CSR_CYCLE:      w_rdata = w_mcycle[HALF_W-1:0];
      CSR_MCYCLEH, CSR_CYCLEH:    w_rdata = w_mcycle[CNT_W-1:HALF_W];
      CSR_MINSTRET, CSR_INSTRET:  w_rdata = w_minstret[HALF_W-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_minstret[CNT_W-1:HALF_W];
      default:                    w_illegal = 1'b1;
    endcase
  end

  assign r_data    = w_rdata;
  assign r_illegal = w_illegal;
  assign mtvec_out = r_mtvec;
  assign mepc_out  = r_mepc;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have rstn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have r_addr, input, 12: CSR read address from the execute stage.
REQ-004 SHALL have r_data, output, 32: combinational read data for r_addr, reflecting pre-edge state.
REQ-005 SHALL have r_illegal, output, 1: high when r_addr is not an implemented CSR.
REQ-006 SHALL have w_enabled, input, 1; w_addr, input, 12; w_data, input, 32: write port driven from the write stage's csr_w_* outputs.
REQ-007 SHALL have retire, input, 1: one instruction retires this cycle.
REQ-008 SHALL have trap, input, 1; trap_pc, input, 32; trap_cause, input, 32: trap entry request.
REQ-009 SHALL have mret, input, 1: return from trap.
REQ-010 SHALL have mtvec_out, output, 32 and mepc_out, output, 32: registered values for fetch redirect.

Function
REQ-011 SHALL implement mstatus 0x300 with MIE (bit 3) and MPIE (bit 7) writable, MPP (bits 12:11) reading 2'b11, all other bits reading 0.
REQ-012 SHALL implement misa 0x301 as read-only 32'h40000100; writes are ignored.
REQ-013 SHALL implement mie 0x304, mscratch 0x340, mcause 0x342, mtval 0x343 as full 32-bit read/write.
REQ-014 SHALL implement mtvec 0x305 and mepc 0x341 with bits 1:0 forced to 0 on every write.
REQ-015 SHALL implement mip 0x344 and mhartid 0xF14 as read-only zero.
REQ-016 SHALL implement 64-bit mcycle (0xB00 low, 0xB80 high) and minstret (0xB02, 0xB82) as read/write.
REQ-017 SHALL mirror them as read-only cycle 0xC00/0xC80 and instret 0xC02/0xC82; writes are ignored.
REQ-018 SHALL increment mcycle by 1 every cycle after reset release.
REQ-019 SHALL increment minstret by 1 in each cycle with retire=1.
REQ-020 SHALL wrap both counters from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-021 SHALL, when a counter half is written in the same cycle as its increment, store w_data in that half, leave the other half unchanged and skip the increment for that cycle.
REQ-022 SHALL ignore writes to unimplemented addresses, with no other side effect.
REQ-023 SHALL drive r_data=0 and r_illegal=1 for unimplemented r_addr.
REQ-024 SHALL perform trap entry on trap=1 at the edge: mepc<=trap_pc with bits 1:0 cleared, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-025 SHALL perform mret=1 at the edge as MIE<=MPIE, MPIE<=1.
REQ-026 SHALL give trap priority over mret when both are high, with mret ignored.
REQ-027 SHALL give trap or mret priority over a software write to mstatus, mepc or mcause in the same cycle; writes to other CSRs in that cycle still take effect.
REQ-028 SHALL show all updates in r_data, mtvec_out and mepc_out from the cycle after the edge, with no write-to-read bypass.

Reset
REQ-029 SHALL clear all CSR registers, both counters and mtvec_out/mepc_out to 0 while rstn=0, independent of clk.
REQ-030 SHALL abandon any write, trap or mret present during reset; mcycle reads 0 in the first cycle after release and 1 in the next.

Structure
REQ-031 SHALL place CSR address constants, mstatus bit positions and the misa value in the shared def.sv package.
REQ-032 SHALL use one sub-module, csr_counter64, instantiated twice: 64-bit register with increment enable and separate low/high write enables, write beating increment.

Verification
REQ-033 SHALL cover reset release then reading 0xB00 on consecutive cycles -> 0, 1, 2.
REQ-034 SHALL cover writing 0xB80=32'hFFFF_FFFF and 0xB00=32'hFFFF_FFFE -> low reads FFFF_FFFF then 0 with high 0 after wrap.
REQ-035 SHALL cover writing mstatus=32'h8 then trap=1, trap_pc=32'h1003, trap_cause=32'd11 -> mepc=32'h1000, mcause=11, mstatus=32'h1880; then mret=1 -> mstatus=32'h1888.
REQ-036 SHALL cover trap=1 with w_enabled=1 to mepc with data 32'h40 in the same cycle -> mepc holds trap_pc, not 32'h40.
REQ-037 SHALL cover writing 0xC00=32'h5 and 0x7C0=32'h5 -> counters unchanged; r_addr=0x7C0 gives r_data=0, r_illegal=1.
REQ-038 SHALL cover retire=1 for 3 cycles with a write of 0xB02=32'h10 on the second -> minstret reads 1, 16, 17.
